fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req_valid  output  1  fetch request present.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  fetch address, word aligned.
REQ-008 imem_rsp_valid  input  1  in-order response, no backpressure.
REQ-009 imem_rsp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump/exception redirect.
REQ-011 redirect_pc  input  32  new fetch PC.
REQ-012 out_valid  output  1  fetched uop valid toward decode.
REQ-013 out_ready  input  1  decode accepts uop.
REQ-014 out_uop  output  Uop::fetch_t  {pc, instr} of head entry.

Function
REQ-015 PC register issues imem_req_addr = pc; on req handshake (valid && ready) pc <= pc + 4, wrapping modulo 2^32.
REQ-016 Credit rule: imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH); a response always finds a free buffer slot.
REQ-017 outstanding counter: +1 on req handshake, -1 on rsp_valid, both same cycle -> unchanged; never exceeds FIFO_DEPTH.
REQ-018 Response with drop_count == 0 pushes {pc_of_request, imem_rsp_data} into buffer; request PCs kept in a matching in-order PC queue.
REQ-019 out_valid = buffer non-empty && !redirect_valid; out_uop = buffer head; pop on out_valid && out_ready.
REQ-020 Simultaneous push and pop on full buffer is legal; pop on empty buffer never occurs.
REQ-021 Redirect cycle: pc <= {redirect_pc[31:2], 2'b00}; buffer and PC queue flushed; no request issued; no uop delivered.
REQ-022 Redirect cycle: drop_count <= outstanding after this cycle's response retires; any response arriving in the redirect cycle is discarded.
REQ-023 While drop_count > 0 each rsp_valid decrements drop_count and is discarded; those slots still count as outstanding until returned.
REQ-024 Request is withdrawable only by redirect; otherwise imem_req_valid and imem_req_addr hold until handshake.
REQ-025 Latency: redirect at cycle N -> imem_req_valid with new PC at N+1; response at cycle M -> out_valid at M+1.
REQ-026 Back-to-back redirects: the last redirect wins; drop_count accumulates correctly across them.

Reset
REQ-027 On rst: pc = RESET_PC, outstanding = 0, drop_count = 0, buffer empty, imem_req_valid = 0, out_valid = 0, perf counter = 0.
REQ-028 Reset mid-operation discards in-flight state; responses to pre-reset requests are not delivered (memory is reset with the core).
REQ-029 First request after reset: cycle after rst deasserts, addr = RESET_PC.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: extra output perf_fetched (32 bits) counts uop handshakes on out, wraps at 2^32, cleared by reset.
REQ-031 FETCH_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.

Structure
REQ-032 Uop package holds fetch_t {pc[31:0], instr[31:0]}; FETCH_DEPTH_DEFAULT and RESET_PC_DEFAULT constants live in the same package.
REQ-033 Buffer implemented as sub-module fetch_fifo (parameterised depth, push/pop/flush, count output); pc, credit and drop logic stay in fetch_stage.

Verification
REQ-034 Reset, memory always ready, 1-cycle response, out_ready=1 -> uops pc 0x0,0x4,0x8... one per cycle, instr matches memory.
REQ-035 out_ready=0 for 10 cycles -> exactly FIFO_DEPTH uops buffered, imem_req_valid low, no loss on release, order preserved.
REQ-036 2 requests outstanding (0x10,0x14), redirect to 0x103 -> both responses dropped, next uop pc 0x100.
REQ-037 Redirect coincident with rsp_valid and out_ready=1 -> that response and head uop discarded, out_valid low that cycle.
REQ-038 imem_req_ready=0 for 5 cycles -> addr held stable, pc unchanged; redirect during stall replaces addr next cycle.
REQ-039 With FETCH_PERF_CNT_EN, 100 delivered uops with 20 stall cycles -> perf_fetched = 100; pc wrap from 0xFFFF_FFFC -> 0x0.

Source files
------------

// File: rtl/Uop.sv
// ---------------------------------------------------------------------------
// Uop -- shared types and defaults for the instruction fetch stage.
//
// Contents:
//   fetch_t             {pc, instr} pair handed from fetch to decode
//   FETCH_DEPTH_DEFAULT default instruction buffer depth
//   RESET_PC_DEFAULT    default PC after reset
//   align_pc()          forces a PC onto a 32-bit word boundary
// ---------------------------------------------------------------------------
package Uop;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  localparam int          FETCH_DEPTH_DEFAULT = 2;
  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo -- small synchronous FIFO with flush, head visible combinationally.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   W      entry width in bits
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset (empties the FIFO)
//   flush_i      empties the FIFO; overrides push/pop in the same cycle
//   push_i       write push_data_i at the tail
//   push_data_i  entry to write
//   pop_i        drop the head entry (never asserted while empty)
//   head_o       current head entry
//   count_o      number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. A push and a pop
  // in the same cycle on a full FIFO is safe: the head is read before the
  // slot is overwritten at the clock edge.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- PC generation, credit-based instruction memory requests,
// redirect handling with stale-response dropping, and an instruction buffer
// feeding decode.
//
// Parameters:
//   RESET_PC    PC loaded on reset
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2)
// Ports:
//   clk, rst                         clock; synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request (word-aligned address)
//   imem_rsp_valid/data              in-order response, no backpressure
//   redirect_valid/redirect_pc       branch/jump/exception redirect
//   out_valid/out_ready/out_uop      {pc, instr} toward decode
//   perf_fetched                     delivered-uop counter (optional)
//
// Build option: define FETCH_PERF_CNT_EN to add the perf_fetched output,
// a wrapping 32-bit count of out_valid && out_ready handshakes.
// ---------------------------------------------------------------------------
module fetch_stage
  import Uop::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output Uop::fetch_t out_uop
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int UW = $bits(fetch_t);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;   // requests accepted, response not yet seen
  logic [CW-1:0] drop_q, drop_d;     // in-flight responses belonging to a dead path

  logic          req_fire;
  logic          rsp_keep;
  logic          pop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] pcq_count;
  logic [31:0]   pcq_head;
  logic [UW-1:0] buf_head;
  fetch_t        push_uop;

  // Every slot either in flight or buffered is reserved, so a returning
  // response always has room in the buffer.
  assign credit_used    = {1'b0, outst_q} + {1'b0, buf_count};
  assign imem_req_valid = !rst && !redirect_valid &&
                          (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only on the live path: not in a redirect cycle and not
  // owed to an earlier redirect. The PC queue check guards against a response
  // with no matching request.
  assign rsp_keep = imem_rsp_valid && !redirect_valid &&
                    (drop_q == '0) && (pcq_count != '0);

  assign push_uop  = '{pc: pcq_head, instr: imem_rsp_data};
  assign out_valid = !rst && !redirect_valid && (buf_count != '0);
  assign out_uop   = fetch_t'(buf_head);
  assign pop       = out_valid && out_ready;

  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d  = drop_q;
    if (redirect_valid) begin
      pc_d   = align_pc(redirect_pc);
      // Everything still in flight after this cycle's response belongs to the
      // abandoned path; outstanding already includes earlier dropped slots,
      // so back-to-back redirects accumulate correctly.
      drop_d = outst_d;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // Instruction buffer toward decode.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (UW)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (rsp_keep),
    .push_data_i (push_uop),
    .pop_i       (pop),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  // PCs of live in-flight requests, in issue order, paired with responses.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_pcq (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (req_fire),
    .push_data_i (pc_q),
    .pop_i       (rsp_keep),
    .head_o      (pcq_head),
    .count_o     (pcq_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (pop) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_fetched = perf_q;
`endif

endmodule
